// File: rtl/frame_config_sequencer.sv
// Frame configuration sequencer: turns a sync-armed command/data word stream into
// FrameData loads followed by a one-hot FrameStrobe pulse of StrobeCycles cycles.
module frame_config_sequencer #(
  parameter int          MaxFramesPerCol = 20,
  parameter int          FrameBitsPerRow = 32,
  parameter int          StrobeCycles    = 1,
  parameter logic [31:0] SyncWord        = 32'hFAB0_FAB1
) (
  input  logic                       CLK,
  input  logic                       reset,
  input  logic [31:0]                s_data,
  input  logic                       s_valid,
  output logic                       s_ready,
  output logic [FrameBitsPerRow-1:0] FrameData,
  output logic [MaxFramesPerCol-1:0] FrameStrobe,
  output logic                       busy,
  output logic                       done,
  output logic                       error,
  output logic [15:0]                frames_written
);

  typedef enum logic [2:0] {IDLE, CMD, DATA, SETUP, STROBE, HOLD} state_t;

  localparam logic [8:0] MaxIdx = 9'(MaxFramesPerCol);
  localparam logic [3:0] StrobeLoad = 4'(StrobeCycles);

  state_t                     state, state_n;
  logic [7:0]                 idx, idx_n;
  logic                       discard, discard_n;
  logic [3:0]                 cnt, cnt_n;
  logic [FrameBitsPerRow-1:0] data_n;
  logic [MaxFramesPerCol-1:0] strobe_n;
  logic                       ready_n, busy_n, done_n, error_n;
  logic [15:0]                count_n;
  logic                       xfer;

  function automatic logic [15:0] sat_inc(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  function automatic logic [MaxFramesPerCol-1:0] onehot(input logic [7:0] i);
    logic [MaxFramesPerCol-1:0] r;
    for (int b = 0; b < MaxFramesPerCol; b++) r[b] = (i == 8'(b));
    return r;
  endfunction

  assign xfer = s_valid && s_ready;

  always_comb begin
    state_n   = state;
    idx_n     = idx;
    discard_n = discard;
    cnt_n     = cnt;
    data_n    = FrameData;
    strobe_n  = FrameStrobe;
    done_n    = 1'b0;
    error_n   = error;
    count_n   = frames_written;
    case (state)
      IDLE: if (xfer && s_data == SyncWord) state_n = CMD;
      CMD: begin
        // A repeated sync word is harmless here even though its opcode is undefined
        if (xfer && s_data != SyncWord) begin
          case (s_data[31:24])
            8'h00: begin end
            8'h01: begin
              idx_n     = s_data[7:0];
              discard_n = ({1'b0, s_data[7:0]} >= MaxIdx);
              if ({1'b0, s_data[7:0]} >= MaxIdx) error_n = 1'b1;
              state_n   = DATA;
            end
            8'h02: begin
              state_n = IDLE;
              done_n  = 1'b1;
            end
            default: error_n = 1'b1;
          endcase
        end
      end
      DATA: begin
        if (xfer) begin
          if (discard) begin
            state_n = CMD;
          end else begin
            data_n  = FrameBitsPerRow'(s_data);
            state_n = SETUP;
          end
        end
      end
      SETUP: begin
        strobe_n = onehot(idx);
        cnt_n    = StrobeLoad;
        state_n  = STROBE;
      end
      STROBE: begin
        if (cnt <= 4'd1) begin
          strobe_n = '0;
          cnt_n    = 4'd0;
          state_n  = HOLD;
        end else begin
          cnt_n = cnt - 4'd1;
        end
      end
      HOLD: begin
        state_n = CMD;
        count_n = sat_inc(frames_written);
      end
      default: state_n = IDLE;
    endcase
    // Handshake and busy are registered from the next state so they line up with it
    ready_n = (state_n == IDLE) || (state_n == CMD) || (state_n == DATA);
    busy_n  = !((state_n == IDLE) || (state_n == CMD));
  end

  always_ff @(posedge CLK) begin
    if (reset) begin
      state          <= IDLE;
      idx            <= 8'd0;
      discard        <= 1'b0;
      cnt            <= 4'd0;
      FrameData      <= '0;
      FrameStrobe    <= '0;
      s_ready        <= 1'b1;
      busy           <= 1'b0;
      done           <= 1'b0;
      error          <= 1'b0;
      frames_written <= 16'd0;
    end else begin
      state          <= state_n;
      idx            <= idx_n;
      discard        <= discard_n;
      cnt            <= cnt_n;
      FrameData      <= data_n;
      FrameStrobe    <= strobe_n;
      s_ready        <= ready_n;
      busy           <= busy_n;
      done           <= done_n;
      error          <= error_n;
      frames_written <= count_n;
    end
  end

endmodule

// File: tb/tb_frame_config_sequencer.sv
// Randomized bench for frame_config_sequencer against a transaction/timeline model.
module tb_frame_config_sequencer;

  localparam int          S    = 4;
  localparam int          MAX  = 20;
  localparam logic [31:0] SYNC = 32'hFAB0_FAB1;

  logic        CLK = 1'b0;
  logic        reset = 1'b1;
  logic [31:0] s_data = '0;
  logic        s_valid = 1'b0;
  logic        s_ready;
  logic [31:0] FrameData;
  logic [19:0] FrameStrobe;
  logic        busy, done, error;
  logic [15:0] frames_written;

  frame_config_sequencer #(
    .MaxFramesPerCol(MAX),
    .FrameBitsPerRow(32),
    .StrobeCycles(S),
    .SyncWord(SYNC)
  ) dut (
    .CLK(CLK),
    .reset(reset),
    .s_data(s_data),
    .s_valid(s_valid),
    .s_ready(s_ready),
    .FrameData(FrameData),
    .FrameStrobe(FrameStrobe),
    .busy(busy),
    .done(done),
    .error(error),
    .frames_written(frames_written)
  );

  always #5 CLK = ~CLK;

  int total = 0;
  int bad = 0;
  int pulses = 0;
  logic [19:0] prev_strobe = '0;

  // Model: mode 0=waiting for sync, 1=command, 2=data, 3=frame timeline in progress
  int          m_mode = 0;
  int          m_t = 0;
  bit          m_discard = 0;
  int          m_idx = 0;
  logic [31:0] m_data = '0;
  bit          m_err = 0;
  bit          m_done = 0;
  int          m_cnt = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic bit m_ready();
    return m_mode != 3;
  endfunction

  task automatic model_step(input bit r, input bit xfer, input logic [31:0] d);
    m_done = 0;
    if (r) begin
      m_mode = 0; m_t = 0; m_discard = 0; m_data = '0; m_err = 0; m_cnt = 0;
    end else if (m_mode == 3) begin
      m_t++;
      if (m_t == S + 2) begin
        m_mode = 1;
        if (m_cnt < 65535) m_cnt++;
      end
    end else if (xfer) begin
      case (m_mode)
        0: if (d == SYNC) m_mode = 1;
        1: begin
          if (d == SYNC) begin end
          else if (d[31:24] == 8'h01) begin
            m_idx = int'(d[7:0]);
            m_discard = (m_idx >= MAX);
            if (m_discard) m_err = 1;
            m_mode = 2;
          end else if (d[31:24] == 8'h02) begin
            m_mode = 0;
            m_done = 1;
          end else if (d[31:24] != 8'h00) begin
            m_err = 1;
          end
        end
        default: begin
          if (m_discard) m_mode = 1;
          else begin
            m_data = d;
            m_mode = 3;
            m_t = 0;
          end
        end
      endcase
    end
  endtask

  task automatic tick(input bit v, input logic [31:0] d, input bit r);
    bit xfer;
    logic [19:0] exp_strobe;
    xfer = v && m_ready() && !r;
    s_valid = v;
    s_data = d;
    reset = r;
    @(posedge CLK);
    #1;
    model_step(r, xfer, d);
    exp_strobe = (m_mode == 3 && m_t >= 1 && m_t <= S) ? (20'd1 << m_idx) : 20'd0;
    chk("s_ready", s_ready, m_ready());
    chk("busy", busy, (m_mode == 2 || m_mode == 3));
    chk("done", done, m_done);
    chk("error", error, m_err);
    chk("frames_written", frames_written, m_cnt);
    chk("FrameData", FrameData, m_data);
    chk("FrameStrobe", FrameStrobe, exp_strobe);
    chk("onehot", ($countones(FrameStrobe) <= 1), 1);
    if (FrameStrobe != 0 && prev_strobe == 0) pulses++;
    prev_strobe = FrameStrobe;
  endtask

  task automatic send(input logic [31:0] w, input bit randv);
    bit v;
    bit sent;
    int n;
    sent = 0;
    n = 0;
    while (!sent) begin
      v = randv ? 1'($urandom_range(0, 1)) : 1'b1;
      sent = v && m_ready();
      tick(v, w, 1'b0);
      n++;
      if (!sent && n > 300) begin
        chk("send_timeout", 0, 1);
        break;
      end
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) tick(1'b0, $urandom, 1'b0);
  endtask

  initial begin
    logic [31:0] w;
    tick(1'b1, 32'h0100_0003, 1'b1);
    tick(1'b0, 32'h0, 1'b1);
    chk("reset_ready", s_ready, 1);
    chk("reset_strobe", FrameStrobe, 0);

    // Pre-sync garbage, sync, END, then a WRITE that must be ignored in IDLE
    for (int i = 0; i < 4; i++) begin
      w = $urandom;
      if (w == SYNC) w = 32'h0;
      send(w, 1'b0);
    end
    send(SYNC, 1'b0);
    send(32'h0200_0000, 1'b0);
    idle(1);
    send(32'h0100_0003, 1'b0);
    send(32'h1234_5678, 1'b0);
    idle(2);
    chk("no_err_presync", error, 0);

    // Single write idx 3, then idx 19
    send(SYNC, 1'b0);
    send(32'h0100_0003, 1'b0);
    send(32'hDEAD_BEEF, 1'b0);
    idle(S + 3);
    chk("count_one", frames_written, 1);
    send(32'h0100_0013, 1'b0);
    send(32'h0000_0001, 1'b0);
    idle(S + 3);

    // NOP, sync in CMD, out-of-range write, undefined opcode, END
    send(32'h0000_0000, 1'b0);
    send(SYNC, 1'b0);
    send(32'h0100_0014, 1'b0);
    send(32'hFFFF_FFFF, 1'b0);
    idle(2);
    chk("err_set", error, 1);
    send(32'h7700_0000, 1'b0);
    send(32'h0200_0000, 1'b0);
    idle(2);

    // Reset in the middle of a strobe with s_valid held high
    send(SYNC, 1'b0);
    send(32'h0100_0005, 1'b0);
    send(32'hA5A5_5A5A, 1'b0);
    tick(1'b1, SYNC, 1'b0);
    tick(1'b1, SYNC, 1'b0);
    chk("mid_strobe", FrameStrobe, 20'h00020);
    tick(1'b1, SYNC, 1'b1);
    chk("rst_strobe", FrameStrobe, 0);
    chk("rst_data", FrameData, 0);
    tick(1'b0, 32'h0, 1'b0);

    // 100 random frames with toggling s_valid and interleaved NOPs
    pulses = 0;
    send(SYNC, 1'b1);
    for (int f = 0; f < 100; f++) begin
      if ($urandom_range(0, 3) == 0) send(32'h0000_0000 | 32'($urandom_range(0, 255)), 1'b1);
      send({8'h01, 16'($urandom), 8'($urandom_range(0, MAX - 1))}, 1'b1);
      send($urandom, 1'b1);
    end
    idle(S + 4);
    chk("pulses_100", pulses, 100);
    chk("frames_100", frames_written, 100);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/frame_config_sequencer.md
FRAME_CONFIG_SEQUENCER -- requirements
Module: frame_config_sequencer

Interface
REQ-001 SHALL have parameter MaxFramesPerCol, default 20, number of frame strobe lines per column.
REQ-002 SHALL have parameter FrameBitsPerRow, default 32, width of the frame data word.
REQ-003 SHALL have parameter StrobeCycles, default 1 (legal 1..15), number of cycles each FrameStrobe pulse is held high.
REQ-004 SHALL have parameter SyncWord, default 32'hFAB0_FAB1, stream word that arms the sequencer.
REQ-005 SHALL have port CLK  input  1  clock; all state updates on its rising edge.
REQ-006 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-007 SHALL have port s_data  input  32  configuration stream word.
REQ-008 SHALL have port s_valid  input  1  s_data valid.
REQ-009 SHALL have port s_ready  output  1  sequencer accepts s_data this cycle.
REQ-010 SHALL have port FrameData  output  FrameBitsPerRow  frame data to the tile config memories.
REQ-011 SHALL have port FrameStrobe  output  MaxFramesPerCol  one-hot frame latch enable.
REQ-012 SHALL have port busy  output  1  high in any state other than IDLE and CMD.
REQ-013 SHALL have port done  output  1  one-cycle pulse on END command.
REQ-014 SHALL have port error  output  1  sticky error flag.
REQ-015 SHALL have port frames_written  output  16  count of completed frame strobes, saturating at 16'hFFFF.

Function
REQ-016 SHALL transfer a word only on a rising edge where s_valid and s_ready are both high.
REQ-017 SHALL implement states IDLE, CMD, DATA, SETUP, STROBE, HOLD; s_ready SHALL be high in IDLE, CMD, DATA and low otherwise.
REQ-018 IDLE: word equal to SyncWord -> CMD; any other word SHALL be consumed and discarded, no error.
REQ-019 CMD: command format opcode = s_data[31:24], frame index = s_data[7:0].
REQ-020 CMD opcode 8'h01 (WRITE) with index < MaxFramesPerCol -> DATA, index latched.
REQ-021 CMD opcode 8'h01 with index >= MaxFramesPerCol SHALL set error and go to DATA with a discard mark; the following data word SHALL be consumed without any strobe.
REQ-022 CMD opcode 8'h02 (END) -> IDLE, with done high for exactly the cycle after acceptance.
REQ-023 CMD opcode 8'h00 (NOP) or a word equal to SyncWord SHALL be consumed with no effect; any other opcode SHALL set error and remain in CMD.
REQ-024 DATA: accepted word (accept edge E0) SHALL load FrameData at E0; state -> SETUP, FrameStrobe all zero.
REQ-025 SETUP lasts one cycle; at E1 FrameStrobe SHALL become one-hot at the latched index, state -> STROBE.
REQ-026 FrameStrobe SHALL stay high exactly StrobeCycles cycles (edges E1 .. E1+StrobeCycles), via a 4-bit down-counter, then return to zero with state -> HOLD.
REQ-027 HOLD lasts one cycle with FrameData unchanged; then -> CMD, and frames_written SHALL increment by 1 on that edge unless already 16'hFFFF.
REQ-028 FrameData SHALL change only on a DATA acceptance edge; it SHALL be stable throughout SETUP, STROBE, HOLD.
REQ-029 FrameStrobe SHALL never have more than one bit set; all outputs SHALL be registered.
REQ-030 Discarded DATA words (REQ-021) SHALL return directly to CMD with FrameData unchanged and no count increment.
REQ-031 error SHALL stay set until reset; setting error SHALL not halt sequencing.

Reset
REQ-032 On reset high at a rising edge: state IDLE, FrameData 0, FrameStrobe 0, done 0, error 0, frames_written 0, strobe counter 0; s_ready SHALL be high the cycle after.
REQ-033 Reset SHALL take priority over any concurrent transfer; reset during STROBE SHALL drop FrameStrobe to 0 at that same edge.

Verification
REQ-034 Sync, WRITE idx 3, data 32'hDEAD_BEEF, StrobeCycles=1 -> FrameData=DEADBEEF one cycle before FrameStrobe=20'h00008 for 1 cycle, frames_written=1, s_ready low 3 cycles.
REQ-035 StrobeCycles=4, WRITE idx 19, data 32'h1 -> FrameStrobe=20'h80000 exactly 4 cycles, FrameData stable SETUP through HOLD.
REQ-036 WRITE idx 20 then data 32'hFFFF_FFFF -> error=1, no strobe, FrameData unchanged, frames_written unchanged, back in CMD.
REQ-037 Words before SyncWord, then END -> pre-sync words discarded without error, done pulses 1 cycle, state IDLE (next WRITE opcode ignored until resync).
REQ-038 Reset asserted mid-STROBE with s_valid held high -> FrameStrobe=0, FrameData=0, error=0, frames_written=0 after the edge; no transfer on that edge.
REQ-039 s_valid toggled randomly across 100 frames -> exactly 100 one-hot strobes, frames_written=100, no multi-hot FrameStrobe observed.
